// File: rtl/nanop_seq.sv
// Three-phase fetch/address/execute sequencer for the nanoprocessor.
// Drives all datapath strobes and owns the carry and zero flags.
module nanop_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] I,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic       Load_I,
  output logic       Load_Ad,
  output logic       Inc_PC,
  output logic       Load_PC,
  output logic       Load_Acc,
  output logic       Sel_Acc,
  output logic       WRITE,
  output logic       Load_Out,
  output logic       Cin,
  output logic       C,
  output logic       Z
);

  typedef enum logic [1:0] {
    ST_IF = 2'd0,
    ST_AF = 2'd1,
    ST_EX = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0] op;
  logic       legal;
  logic       is_alu, is_cop, is_cin, is_lda;
  logic       is_sta, is_out, is_jmp, is_jnc, is_jnz;

  assign op    = I[3:0];
  assign legal = (I[7:4] == 4'h0);

  // Nonzero upper nibble decodes to nothing, i.e. a NOP.
  always_comb begin
    is_alu = 1'b0;
    is_cop = 1'b0;
    is_cin = 1'b0;
    is_lda = 1'b0;
    is_sta = 1'b0;
    is_out = 1'b0;
    is_jmp = 1'b0;
    is_jnc = 1'b0;
    is_jnz = 1'b0;
    if (legal) begin
      is_alu = (op >= 4'h1) && (op <= 4'h9);
      is_cop = (op >= 4'h4) && (op <= 4'h9);
      is_cin = (op == 4'h5) || (op == 4'h7) ||
               (op == 4'h8) || (op == 4'h9);
      is_lda = (op == 4'hA);
      is_sta = (op == 4'hB);
      is_out = (op == 4'hC);
      is_jmp = (op == 4'hD);
      is_jnc = (op == 4'hE);
      is_jnz = (op == 4'hF);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IF;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      C <= 1'b0;
      Z <= 1'b0;
    end else if (en && state == ST_EX) begin
      if (is_cop) C <= alu_c;
      if (is_alu || is_lda) Z <= alu_z;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      unique case (state)
        ST_IF:   state_nxt = ST_AF;
        ST_AF:   state_nxt = ST_EX;
        ST_EX:   state_nxt = ST_IF;
        default: state_nxt = ST_IF;
      endcase
    end
  end

  always_comb begin
    Load_I   = 1'b0;
    Load_Ad  = 1'b0;
    Inc_PC   = 1'b0;
    Load_PC  = 1'b0;
    Load_Acc = 1'b0;
    WRITE    = 1'b0;
    Load_Out = 1'b0;
    Cin      = reset_n & is_cin & C;
    Sel_Acc  = reset_n & (state == ST_EX) & is_lda;
    if (reset_n && en) begin
      unique case (state)
        ST_IF: begin
          Load_I = 1'b1;
          Inc_PC = 1'b1;
        end
        ST_AF: begin
          Load_Ad = 1'b1;
          Inc_PC  = 1'b1;
        end
        ST_EX: begin
          unique case (1'b1)
            is_alu, is_lda: Load_Acc = 1'b1;
            is_sta:         WRITE    = 1'b1;
            is_out:         Load_Out = 1'b1;
            is_jmp:         Load_PC  = 1'b1;
            is_jnc:         Load_PC  = ~C;
            is_jnz:         Load_PC  = ~Z;
            default:        ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nanop_seq.md
# nanop_seq

Three-phase instruction sequencer for the full (step 4) nanoprocessor instruction set. It sits between the instruction register and the datapath (PC, address register, ALU, accumulator, memory, output port). It drives every load/write strobe, the jump decision and the ALU carry input, and it owns the carry (C) and zero (Z) flag registers.

## Interface

- No parameters.
- clk      in   1  system clock, rising edge active
- reset_n  in   1  asynchronous active-low reset
- en       in   1  run enable; low freezes the sequencer
- I        in   8  current instruction register contents
- alu_c    in   1  ALU carry/borrow/shifted-out bit for the current operation
- alu_z    in   1  1 when the ALU result (or the loaded value for LDA) is 0x00
- Load_I   out  1  load instruction register from memory data
- Load_Ad  out  1  load operand-address register from memory data
- Inc_PC   out  1  PC <= PC + 1
- Load_PC  out  1  PC <= address register (jump taken)
- Load_Acc out  1  accumulator load
- Sel_Acc  out  1  1 = accumulator takes memory data; 0 = accumulator takes ALU result
- WRITE    out  1  memory write of accumulator at the address register
- Load_Out out  1  output port load from accumulator
- Cin      out  1  ALU carry-in, equal to the C flag for ADC/SBC/ROL/ROR, else 0
- C        out  1  carry flag register
- Z        out  1  zero flag register

## Operation

- Opcodes: NOP 0x00, XOR 0x01, AND 0x02, OR 0x03, ADD 0x04, ADC 0x05, SUB 0x06, SBC 0x07, ROL 0x08, ROR 0x09, LDA 0x0A, STA 0x0B, OUT 0x0C, JMP 0x0D, JNC 0x0E, JNZ 0x0F.
- Any I with a nonzero upper nibble executes as NOP.
- FSM states are IF, AF and EX. Transitions are IF->AF->EX->IF, each taken only when en=1.
- IF: Load_I=1, Inc_PC=1.
- AF: Load_Ad=1, Inc_PC=1.
- EX for ALU ops (0x01–0x09): Load_Acc=1, Sel_Acc=0.
- EX for LDA: Load_Acc=1, Sel_Acc=1.
- EX for STA: WRITE=1.
- EX for OUT: Load_Out=1.
- EX for JMP: Load_PC=1.
- EX for JNC: Load_PC = !C.
- EX for JNZ: Load_PC = !Z.
- EX for NOP: no strobe.
- Flag updates are sampled at the rising edge that ends EX:
  - C <= alu_c for ADD, ADC, SUB, SBC, ROL, ROR.
  - Z <= alu_z for all ALU ops 0x01–0x09 and for LDA.
  - All other instructions leave both flags unchanged.
- Every strobe not listed for a state is 0.
- Outputs are combinational from state, I, C, Z, en and reset_n.
- When en=0:
  - State, C and Z hold.
  - All strobes are 0 (Load_I, Load_Ad, Inc_PC, Load_PC, Load_Acc, WRITE, Load_Out).
  - Sel_Acc and Cin still follow the decode.
- When reset_n=0:
  - State goes to IF, C=0, Z=0, asynchronously.
  - All strobes are forced to 0 while reset is low, so a memory write is never issued during reset.

## Timing

- Reset values: state IF, C=0, Z=0. All outputs are 0 while reset_n is low.
- On the first rising edge after reset_n deasserts with en=1, the IF strobes are active, so the instruction at PC=0 is captured.
- Every instruction, including NOP and jumps, takes exactly 3 enabled cycles.
- A taken jump loads the PC at the end of EX, so the next IF fetches from the target.
- Jump conditions use the flag values held during EX. Jumps never modify the flags, so there is no hazard.
- Cin reflects C before the EX-ending edge. ADC followed by ADC therefore chains correctly.
- en deasserted mid-instruction: the FSM resumes in the same state with the same flags when en returns. No strobe repeats and none is lost.
- Reset asserted during EX of STA: WRITE drops in the same cycle, combinationally, and the state becomes IF.
- en=0 and reset_n=0 together: reset wins.

## Test plan

- Reset then en=1, I=0x04 (ADD), alu_c=1, alu_z=0 -> strobes IF:Load_I+Inc_PC, AF:Load_Ad+Inc_PC, EX:Load_Acc with Sel_Acc=0; after EX, C=1 and Z=0.
- Set C=1, then I=0x05 (ADC) -> Cin=1 during EX. Then I=0x02 (AND) -> Cin=0 and C still 1 after EX.
- LDA with alu_z=1 -> Z=1 after EX. Then JNZ -> Load_PC=0. Then JNC with C=0 -> Load_PC=1 in EX only.
- I=0x0B (STA) -> WRITE=1 only in the EX cycle. Assert reset_n=0 mid-EX -> WRITE drops immediately and state returns to IF.
- Drop en for 5 cycles during AF of OUT -> no strobes while en is low. Load_Out pulses exactly once, one cycle after AF completes.
- I=0x3C and I=0xFF -> behave as NOP: 3 cycles, no Load_Acc/WRITE/Load_PC/Load_Out, flags unchanged.
